// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM (st/oe/addr/data) between the
// CPU instruction-fetch port (I) and the data port (D).
// - Each access goes through IDLE -> ACCESS -> DONE. Round-robin decides
//   which port wins when both ports request in the same IDLE cycle.
// - Reads hold mem_oe for RD_LAT cycles. Writes (D port only) pulse mem_st
//   for one cycle.
// - The owner receives a one-cycle ack in DONE.
// - All outputs are registered.
// Optional feature: define ARB_STATS_EN to add the saturating 16-bit grant
// counters i_grant_cnt / d_grant_cnt.
module mem_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1    // legal range 1-4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
`ifdef ARB_STATS_EN
  output logic [15:0]       i_grant_cnt,
  output logic [15:0]       d_grant_cnt,
`endif
  output logic              mem_st,
  output logic              mem_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam int LAT_W = 2;  // counts 0..RD_LAT-1, RD_LAT <= 4

  state_t           state;
  logic             owner_d;   // 1 = current access belongs to the D port
  logic             last_d;    // 1 = last grant went to D, 0 = to I
  logic             op_we;     // latched write flag of the current access
  logic [LAT_W-1:0] lat_cnt;
  logic             any_req;
  logic             grant_d;

  // Arbitration decision for the current IDLE cycle: on a tie, grant the
  // port that did not win last time.
  // NOTE: combinational blocks assign every output unconditionally, so no
  // latch is inferred.
  always_comb begin
    any_req = i_req | d_req;
    grant_d = d_req & (~i_req | ~last_d);
  end

  // Access sequencer. It owns every registered output and the arbitration
  // history.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the other registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: there is no RAM array here. Only the flops are reset, and that
      // includes the rdata holding registers, so an aborted read leaves no
      // stale data.
      state     <= IDLE;
      owner_d   <= 1'b0;
      last_d    <= 1'b0;
      op_we     <= 1'b0;
      lat_cnt   <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      mem_st    <= 1'b0;
      mem_oe    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          i_ack <= 1'b0;
          d_ack <= 1'b0;
          if (any_req) begin
            owner_d  <= grant_d;
            last_d   <= grant_d;
            op_we    <= grant_d & d_we;
            lat_cnt  <= '0;
            mem_addr <= grant_d ? d_addr : i_addr;
            if (grant_d) mem_wdata <= d_wdata;
            // Only the D port can write. A fetch is always a read.
            mem_st   <= grant_d & d_we;
            mem_oe   <= ~(grant_d & d_we);
            state    <= ACCESS;
          end else begin
            mem_st <= 1'b0;
            mem_oe <= 1'b0;
          end
        end

        ACCESS: begin
          if (op_we) begin
            mem_st <= 1'b0;
            d_ack  <= 1'b1;
            state  <= DONE;
          end else if (lat_cnt == LAT_W'(RD_LAT - 1)) begin
            // Last cycle with oe high: the RAM data is valid now.
            mem_oe <= 1'b0;
            if (owner_d) begin
              d_rdata <= mem_rdata;
              d_ack   <= 1'b1;
            end else begin
              i_rdata <= mem_rdata;
              i_ack   <= 1'b1;
            end
            state <= DONE;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end

        DONE: begin
          i_ack  <= 1'b0;
          d_ack  <= 1'b0;
          mem_st <= 1'b0;
          mem_oe <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  // Saturating per-port grant counters. Each counter steps at the grant made
  // in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      i_grant_cnt <= '0;
      d_grant_cnt <= '0;
    end else if (state == IDLE && any_req) begin
      if (grant_d) begin
        if (d_grant_cnt != 16'hFFFF) d_grant_cnt <= d_grant_cnt + 1'b1;
      end else begin
        if (i_grant_cnt != 16'hFFFF) i_grant_cnt <= i_grant_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized self-checking bench for mem_port_arbiter
// with RD_LAT = 3. The bench contains:
// - A behavioural RAM that returns valid data only in the RD_LAT-th
//   consecutive oe cycle.
// - A transaction-level reference model covering round-robin choice,
//   expected ack cycle, strobe windows, and memory contents.
// Define ARB_STATS_EN to also check the grant counters.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int RD_LAT = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_req, d_req, d_we;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              i_ack, d_ack, mem_st, mem_oe;
  logic [DATA_W-1:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
`ifdef ARB_STATS_EN
  logic [15:0]       i_grant_cnt, d_grant_cnt;
`endif

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
`ifdef ARB_STATS_EN
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt),
`endif
    .mem_st(mem_st), .mem_oe(mem_oe), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: data is valid only once oe has been high RD_LAT cycles.
  logic [DATA_W-1:0] ram [256];
  int oe_run = 0;
  always @(posedge clk) oe_run <= mem_oe ? oe_run + 1 : 0;
  assign mem_rdata = (mem_oe && oe_run >= RD_LAT - 1) ? ram[mem_addr] : 16'hDEAD;

  // Bookkeeping and reference model state.
  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [DATA_W-1:0] exp_mem [256];
  bit                busy, owner_d, last_d, g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata, g_data, exp_i, exp_d;
  int                g_cyc, ack_due, next_idle;
  int                exp_ig, exp_dg;
  bit                i_dropped, d_dropped;
  int                ack_order[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Decide the grant for requests that the next edge samples in IDLE.
  task automatic arbitrate();
    bit win_d;
    if (!busy && cyc >= next_idle && (i_req || d_req)) begin
      if (i_req && d_req) win_d = !last_d;
      else                win_d = d_req;
      last_d  = win_d;
      owner_d = win_d;
      g_we    = win_d && d_we;
      g_addr  = win_d ? d_addr : i_addr;
      g_wdata = d_wdata;
      g_cyc   = cyc;
      ack_due = cyc + (g_we ? 2 : RD_LAT + 1);
      next_idle = ack_due + 1;
      busy    = 1'b1;
      if (g_we) exp_mem[g_addr] = g_wdata;
      else      g_data = exp_mem[g_addr];
      if (win_d) begin if (exp_dg < 16'hFFFF) exp_dg++; end
      else       begin if (exp_ig < 16'hFFFF) exp_ig++; end
    end
  endtask

  // Compare every output against the model for the current cycle.
  task automatic check_outputs();
    logic [1:0] ea;
    bit est, eoe, in_acc;
    ea = 2'b00; est = 0; eoe = 0; in_acc = 0;
    i_dropped = 0; d_dropped = 0;
    if (busy) begin
      if (cyc == ack_due) begin
        ea = owner_d ? 2'b01 : 2'b10;
        if (!g_we) begin
          if (owner_d) exp_d = g_data;
          else         exp_i = g_data;
        end
      end else if (cyc > g_cyc && cyc <= g_cyc + (g_we ? 1 : RD_LAT)) begin
        in_acc = 1;
        if (g_we) est = 1;
        else      eoe = 1;
      end
    end
    check("acks", {30'd0, i_ack, d_ack}, {30'd0, ea});
    check("strobes", {30'd0, mem_st, mem_oe}, {30'd0, est, eoe});
    if (in_acc) check("mem_addr", 32'(mem_addr), 32'(g_addr));
    if (est)    check("mem_wdata", 32'(mem_wdata), 32'(g_wdata));
    check("i_rdata", 32'(i_rdata), 32'(exp_i));
    check("d_rdata", 32'(d_rdata), 32'(exp_d));
    if (i_ack) ack_order.push_back(0);
    if (d_ack) ack_order.push_back(1);
    if (mem_st) ram[mem_addr] = mem_wdata;
    if (busy && cyc == ack_due) begin
      busy = 1'b0;
      if (owner_d) begin d_req = 1'b0; d_dropped = 1; end
      else         begin i_req = 1'b0; i_dropped = 1; end
    end
  endtask

  task automatic model_reset();
    busy = 0; last_d = 0; exp_i = '0; exp_d = '0;
    exp_ig = 0; exp_dg = 0; next_idle = cyc;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_strobes_acks"}, {28'd0, i_ack, d_ack, mem_st, mem_oe}, 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_rdata"}, {i_rdata, d_rdata}, 32'd0);
`ifdef ARB_STATS_EN
    check({tag, "_grant_cnts"}, {i_grant_cnt, d_grant_cnt}, 32'd0);
`endif
  endtask

  initial begin
    int cnt;
    bit got_dack;
    reset = 1; i_req = 0; d_req = 0; d_we = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    for (int a = 0; a < 256; a++) begin
      ram[a] = 16'($urandom);
      exp_mem[a] = ram[a];
    end
    ram[8'h10] = 16'hBEEF; exp_mem[8'h10] = 16'hBEEF;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 0;
    model_reset();

    // Contention: both ports held high, expected grant order D, I, D, I.
    i_req = 1; i_addr = 8'h10; d_req = 1; d_we = 0; d_addr = 8'h22;
    arbitrate();
    cnt = 0;
    while (ack_order.size() < 4 && cnt < 60) begin
      tick(); check_outputs();
      if (i_dropped) i_req = 1;
      if (d_dropped) d_req = 1;
      arbitrate();
      cnt++;
    end
    check("contention_acks", ack_order.size(), 4);
    for (int k = 0; k < 4 && k < ack_order.size(); k++)
      check($sformatf("contention_order%0d", k), ack_order[k], (k % 2 == 0) ? 1 : 0);

    // Randomized traffic from both ports.
    for (int n = 0; n < 1500; n++) begin
      tick(); check_outputs();
      if (!i_req && !i_dropped && $urandom_range(0, 2) == 0) begin
        i_req = 1; i_addr = 8'($urandom_range(0, 15));
      end
      if (!d_req && !d_dropped && $urandom_range(0, 2) == 0) begin
        d_req = 1; d_we = 1'($urandom); d_addr = 8'($urandom_range(0, 15));
        d_wdata = 16'($urandom);
      end
      arbitrate();
    end

    // Drain outstanding traffic.
    cnt = 0;
    while ((busy || i_req || d_req) && cnt < 40) begin
      tick(); check_outputs(); arbitrate(); cnt++;
    end
    check("drain_idle", {30'd0, i_req, d_req}, 32'd0);

    // Reset during the first ACCESS cycle of a fetch.
    i_req = 1; i_addr = 8'h05;
    arbitrate();
    tick(); check_outputs();
    reset = 1;
    tick();
    check_all_zero("abort");
    reset = 0; i_req = 0;
    model_reset();
    d_req = 1; d_we = 0; d_addr = 8'h05;
    arbitrate();
    got_dack = 0; cnt = 0;
    while (busy && cnt < 20) begin
      tick(); check_outputs();
      if (d_dropped) got_dack = 1;
      cnt++;
    end
    check("post_reset_dack", {31'd0, got_dack}, 32'd1);

`ifdef ARB_STATS_EN
    check("i_grant_cnt", 32'(i_grant_cnt), exp_ig);
    check("d_grant_cnt", 32'(d_grant_cnt), exp_dg);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
